// File: rtl/icache_direct.sv
// Direct-mapped instruction cache: one 32-bit word per entry, single-word refill
// through mem_control's PC port. Hits answer one cycle after the request.
module icache_direct #(
   parameter int unsigned INDEX_BITS = 8,
   parameter int unsigned ADDR_W     = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              clear,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_pc,
   output logic              fetch_ready,
   output logic              inst_valid,
   output logic [31:0]       inst_out,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_done,
   input  logic [31:0]       mem_inst
);

   localparam int unsigned ENTRIES = 2 ** INDEX_BITS;
   localparam int unsigned TAG_W   = ADDR_W - INDEX_BITS - 2;

   localparam logic STATE_IDLE = 1'b0;
   localparam logic STATE_MISS = 1'b1;

   logic                  state_q;
   logic                  squash_q;
   logic [ADDR_W-3:0]     miss_pc_q;
   logic [ENTRIES-1:0]    valid_q;
   logic [TAG_W-1:0]      tag_mem  [ENTRIES];
   logic [31:0]           data_mem [ENTRIES];

   logic [INDEX_BITS-1:0] fetch_idx;
   logic [TAG_W-1:0]      fetch_tag;
   logic [INDEX_BITS-1:0] miss_idx;
   logic [TAG_W-1:0]      miss_tag;
   logic                  hit;
   logic                  accept;
   logic                  refill;
   logic                  unused_pc_lsb;

   assign fetch_idx = fetch_pc[INDEX_BITS+1:2];
   assign fetch_tag = fetch_pc[ADDR_W-1:INDEX_BITS+2];
   assign miss_idx  = miss_pc_q[INDEX_BITS-1:0];
   assign miss_tag  = miss_pc_q[ADDR_W-3:INDEX_BITS];

   // Byte offset within the word is irrelevant to an instruction fetch.
   assign unused_pc_lsb = ^fetch_pc[1:0];

   assign fetch_ready = (state_q == STATE_IDLE) && !rst;
   assign accept      = fetch_req && fetch_ready && rdy && !clear;
   assign hit         = valid_q[fetch_idx] && (tag_mem[fetch_idx] == fetch_tag);
   assign refill      = (state_q == STATE_MISS) && mem_done && rdy;
   assign mem_addr    = {miss_pc_q, 2'b00};

   // Tag/data arrays carry no reset; only the valid bits do.
   always_ff @(posedge clk) begin
      if (!rst && refill) begin
         tag_mem[miss_idx]  <= miss_tag;
         data_mem[miss_idx] <= mem_inst;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q    <= '0;
         state_q    <= STATE_IDLE;
         squash_q   <= 1'b0;
         miss_pc_q  <= '0;
         inst_valid <= 1'b0;
         inst_out   <= 32'h0;
         mem_req    <= 1'b0;
      end else if (rdy) begin
         inst_valid <= 1'b0;
         case (state_q)
            STATE_IDLE: begin
               if (accept) begin
                  if (hit) begin
                     inst_valid <= 1'b1;
                     inst_out   <= data_mem[fetch_idx];
                  end else begin
                     miss_pc_q <= fetch_pc[ADDR_W-1:2];
                     mem_req   <= 1'b1;
                     state_q   <= STATE_MISS;
                  end
               end
            end
            STATE_MISS: begin
               // A refill cannot be aborted, so a flush only suppresses its response.
               if (mem_done) begin
                  valid_q[miss_idx] <= 1'b1;
                  mem_req           <= 1'b0;
                  state_q           <= STATE_IDLE;
                  squash_q          <= 1'b0;
                  if (!squash_q && !clear) begin
                     inst_valid <= 1'b1;
                     inst_out   <= mem_inst;
                  end
               end else if (clear) begin
                  squash_q <= 1'b1;
               end
            end
            default: state_q <= STATE_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_icache_direct.sv
// Bench for icache_direct: directed vector table for the corner cases, then random
// traffic against a word-addressed cache model with a randomized-latency memory.
module tb_icache_direct;

   logic        clk = 1'b0;
   logic        rst;
   logic        rdy;
   logic        clear;
   logic        fetch_req;
   logic [31:0] fetch_pc;
   logic        fetch_ready;
   logic        inst_valid;
   logic [31:0] inst_out;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_done;
   logic [31:0] mem_inst;

   int checks = 0;
   int errors = 0;

   icache_direct #(
      .INDEX_BITS(8),
      .ADDR_W    (32)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rdy        (rdy),
      .clear      (clear),
      .fetch_req  (fetch_req),
      .fetch_pc   (fetch_pc),
      .fetch_ready(fetch_ready),
      .inst_valid (inst_valid),
      .inst_out   (inst_out),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_done   (mem_done),
      .mem_inst   (mem_inst)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst, rdy, clr, req;
      logic [31:0] pc;
      logic        done;
      logic [31:0] inst;
      logic        iv, chk_all;
      logic [31:0] out;
      logic        mreq;
      logic [31:0] maddr;
      logic        fr;
   } vec_t;

   vec_t vecs[$];

   typedef struct {
      logic [29:0] word;
      logic [31:0] data;
   } line_t;

   line_t cache[int];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic y, input logic c, input logic q,
                      input logic [31:0] pc, input logic d, input logic [31:0] inst,
                      input logic iv, input logic chk, input logic [31:0] out,
                      input logic mreq, input logic [31:0] maddr, input logic fr);
      vec_t v;
      v.rst = r; v.rdy = y; v.clr = c; v.req = q; v.pc = pc; v.done = d; v.inst = inst;
      v.iv = iv; v.chk_all = chk; v.out = out; v.mreq = mreq; v.maddr = maddr; v.fr = fr;
      vecs.push_back(v);
   endtask

   initial begin
      logic        busy, sq, e_iv;
      logic [31:0] e_out;
      logic [29:0] pend, w;
      int          lat, idx;

      rst = 1'b1; rdy = 1'b1; clear = 1'b0; fetch_req = 1'b0; fetch_pc = '0;
      mem_done = 1'b0; mem_inst = '0;

      // rst rdy clr req pc done inst | iv chk out mreq maddr fr
      // Cold miss at 0, then hit.
      add(1, 1, 0, 0, 32'h0,   0, 32'h0,        0, 1, 32'h0,        0, 32'h0,   0);
      add(0, 1, 0, 0, 32'h0,   0, 32'h0,        0, 1, 32'h0,        0, 32'h0,   1);
      add(0, 1, 0, 1, 32'h0,   0, 32'h0,        0, 0, 32'h0,        1, 32'h0,   0);
      add(0, 1, 0, 0, 32'h0,   0, 32'h0,        0, 0, 32'h0,        1, 32'h0,   0);
      add(0, 1, 0, 0, 32'h0,   1, 32'h13,       1, 0, 32'h13,       0, 32'h0,   1);
      add(0, 1, 0, 1, 32'h0,   0, 32'h0,        1, 0, 32'h13,       0, 32'h0,   1);
      add(0, 1, 0, 0, 32'h0,   0, 32'h0,        0, 0, 32'h0,        0, 32'h0,   1);
      // Aliasing 0x400 evicts 0x0.
      add(0, 1, 0, 1, 32'h400, 0, 32'h0,        0, 0, 32'h0,        1, 32'h400, 0);
      add(0, 1, 0, 0, 32'h0,   1, 32'hDEADBEEF, 1, 0, 32'hDEADBEEF, 0, 32'h0,   1);
      add(0, 1, 0, 1, 32'h400, 0, 32'h0,        1, 0, 32'hDEADBEEF, 0, 32'h0,   1);
      add(0, 1, 0, 1, 32'h0,   0, 32'h0,        0, 0, 32'h0,        1, 32'h0,   0);
      add(0, 1, 0, 0, 32'h0,   1, 32'h13,       1, 0, 32'h13,       0, 32'h0,   1);
      // Flush during miss at 0x8: refill lands silently, later hits.
      add(0, 1, 0, 1, 32'h8,   0, 32'h0,        0, 0, 32'h0,        1, 32'h8,   0);
      add(0, 1, 0, 0, 32'h0,   0, 32'h0,        0, 0, 32'h0,        1, 32'h8,   0);
      add(0, 1, 1, 0, 32'h0,   0, 32'h0,        0, 0, 32'h0,        1, 32'h8,   0);
      add(0, 1, 0, 0, 32'h0,   0, 32'h0,        0, 0, 32'h0,        1, 32'h8,   0);
      add(0, 1, 0, 0, 32'h0,   1, 32'hAAAA0008, 0, 0, 32'h0,        0, 32'h0,   1);
      add(0, 1, 0, 1, 32'h8,   0, 32'h0,        1, 0, 32'hAAAA0008, 0, 32'h0,   1);
      add(0, 1, 1, 1, 32'h0,   0, 32'h0,        0, 0, 32'h0,        0, 32'h0,   1);
      // rdy low across a hit response and across a pending miss.
      add(0, 1, 0, 1, 32'h8,   0, 32'h0,        1, 0, 32'hAAAA0008, 0, 32'h0,   1);
      for (int k = 0; k < 3; k++)
         add(0, 0, 0, 1, 32'h0, 0, 32'h0,       1, 0, 32'hAAAA0008, 0, 32'h0,   1);
      add(0, 1, 0, 0, 32'h0,   0, 32'h0,        0, 0, 32'h0,        0, 32'h0,   1);
      add(0, 1, 0, 1, 32'h10,  0, 32'h0,        0, 0, 32'h0,        1, 32'h10,  0);
      for (int k = 0; k < 3; k++)
         add(0, 0, 0, 0, 32'h0, 0, 32'h0,       0, 0, 32'h0,        1, 32'h10,  0);
      add(0, 1, 0, 0, 32'h0,   1, 32'h11110010, 1, 0, 32'h11110010, 0, 32'h0,   1);
      // Reset mid-miss, stale done ignored, then clear coincident with done.
      add(0, 1, 0, 1, 32'hC,   0, 32'h0,        0, 0, 32'h0,        1, 32'hC,   0);
      add(1, 1, 0, 0, 32'h0,   0, 32'h0,        0, 1, 32'h0,        0, 32'h0,   0);
      add(0, 1, 0, 0, 32'h0,   1, 32'h55,       0, 1, 32'h0,        0, 32'h0,   1);
      add(0, 1, 0, 1, 32'hC,   0, 32'h0,        0, 0, 32'h0,        1, 32'hC,   0);
      add(0, 1, 1, 0, 32'h0,   1, 32'h77,       0, 0, 32'h0,        0, 32'h0,   1);
      add(0, 1, 0, 1, 32'hC,   0, 32'h0,        1, 0, 32'h77,       0, 32'h0,   1);
      add(0, 1, 0, 0, 32'h0,   0, 32'h0,        0, 0, 32'h0,        0, 32'h0,   1);

      for (int k = 0; k < vecs.size(); k++) begin
         rst = vecs[k].rst; rdy = vecs[k].rdy; clear = vecs[k].clr;
         fetch_req = vecs[k].req; fetch_pc = vecs[k].pc;
         mem_done = vecs[k].done; mem_inst = vecs[k].inst;
         tick();
         check($sformatf("row%0d inst_valid", k), {31'h0, inst_valid}, {31'h0, vecs[k].iv});
         if (vecs[k].iv || vecs[k].chk_all)
            check($sformatf("row%0d inst_out", k), inst_out, vecs[k].out);
         check($sformatf("row%0d mem_req", k), {31'h0, mem_req}, {31'h0, vecs[k].mreq});
         if (vecs[k].mreq || vecs[k].chk_all)
            check($sformatf("row%0d mem_addr", k), mem_addr, vecs[k].maddr);
         check($sformatf("row%0d fetch_ready", k), {31'h0, fetch_ready}, {31'h0, vecs[k].fr});
      end

      // Random traffic over 3 tags x 3 indices so aliasing is frequent.
      rst = 1'b1; rdy = 1'b1; clear = 1'b0; fetch_req = 1'b0; mem_done = 1'b0;
      tick();
      rst = 1'b0;
      cache.delete();
      busy = 1'b0; sq = 1'b0; e_iv = 1'b0; e_out = '0; pend = '0; lat = 0;
      for (int n = 0; n < 3000; n++) begin
         rdy       = ($urandom_range(7) != 0);
         clear     = ($urandom_range(9) == 0);
         fetch_req = ($urandom_range(3) != 0);
         fetch_pc  = ($urandom_range(2) << 10) | ($urandom_range(2) << 2) | $urandom_range(3);
         mem_inst  = $urandom;
         mem_done  = 1'b0;
         if (busy && rdy) begin
            if (lat == 0) mem_done = 1'b1;
            else lat--;
         end
         if (rdy) begin
            e_iv = 1'b0;
            if (!busy) begin
               if (fetch_req && !clear) begin
                  w   = fetch_pc[31:2];
                  idx = int'(w % 256);
                  if (cache.exists(idx) && cache[idx].word == w) begin
                     e_iv  = 1'b1;
                     e_out = cache[idx].data;
                  end else begin
                     busy = 1'b1; pend = w; sq = 1'b0; lat = $urandom_range(3);
                  end
               end
            end else if (mem_done) begin
               idx = int'(pend % 256);
               cache[idx].word = pend;
               cache[idx].data = mem_inst;
               busy = 1'b0;
               if (!sq && !clear) begin
                  e_iv  = 1'b1;
                  e_out = mem_inst;
               end
            end else if (clear) begin
               sq = 1'b1;
            end
         end
         tick();
         check($sformatf("rnd%0d inst_valid", n), {31'h0, inst_valid}, {31'h0, e_iv});
         if (e_iv) check($sformatf("rnd%0d inst_out", n), inst_out, e_out);
         check($sformatf("rnd%0d mem_req", n), {31'h0, mem_req}, {31'h0, busy});
         if (busy) check($sformatf("rnd%0d mem_addr", n), mem_addr, {pend, 2'b00});
         check($sformatf("rnd%0d fetch_ready", n), {31'h0, fetch_ready}, {31'h0, !busy});
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
